// File: rtl/rst_seq.sv
// Reset sequencer: holds all downstream domains in reset for a minimum width, then releases them
// one at a time in index order with a per-stage gap and an optional ready ack (timeout forces advance).
module rst_seq #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
  input  logic                wdt_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] rst_n_out,
  output logic                seq_busy,
  output logic [1:0]          rst_cause,
  output logic                ack_timeout
);

  localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_REL    = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                state, nxt_state;
  logic [CW-1:0]         cnt, nxt_cnt;
  logic [IW-1:0]         idx, nxt_idx;
  logic [1:0]            nxt_cause;
  logic                  nxt_timeout;
  logic [N_STAGES-1:0]   nxt_rst_n;
  logic                  nxt_busy;
  logic                  ack_ok;
  logic                  tmo_hit;
  logic                  adv;

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = (cnt == CW'(CNT_MAX)) ? cnt : cnt + CW'(1);
    nxt_idx     = idx;
    nxt_cause   = rst_cause;
    nxt_timeout = ack_timeout;
    ack_ok      = (cnt >= CW'(GAP_CYCLES - 1)) && stage_ack[idx];
    tmo_hit     = (cnt == CW'(ACK_TIMEOUT - 1));
    adv         = 1'b0;

    // A request wins over any in-flight advance and pins the hold counter at zero.
    if (sw_rst_req || wdt_rst_req) begin
      nxt_state   = ST_ASSERT;
      nxt_cnt     = '0;
      nxt_idx     = '0;
      nxt_timeout = 1'b0;
      nxt_cause   = wdt_rst_req ? 2'b10 : 2'b01;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            nxt_state = ST_REL;
            nxt_cnt   = '0;
            nxt_idx   = '0;
          end
        end
        ST_REL: begin
          if (ack_ok || tmo_hit) begin
            adv = 1'b1;
          end
          if (tmo_hit && !ack_ok) begin
            nxt_timeout = 1'b1;
          end
          if (adv) begin
            nxt_cnt = '0;
            if (idx < IW'(N_STAGES - 1)) begin
              nxt_idx = idx + IW'(1);
            end else begin
              nxt_state = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          nxt_cnt = cnt;
        end
        default: begin
          nxt_state = ST_ASSERT;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      endcase
    end

    nxt_busy = (nxt_state != ST_RUN);
    for (int j = 0; j < N_STAGES; j++) begin
      nxt_rst_n[j] = (nxt_state == ST_RUN) ||
                     ((nxt_state == ST_REL) && (j <= int'(nxt_idx)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      seq_busy    <= 1'b1;
      rst_cause   <= 2'b00;
      ack_timeout <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      rst_n_out   <= nxt_rst_n;
      seq_busy    <= nxt_busy;
      rst_cause   <= nxt_cause;
      ack_timeout <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed release-timing scenarios plus randomized traffic against an edge-timeline model.
module tb_rst_seq;
  localparam int N    = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int ATO  = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_rst_req;
  logic         wdt_rst_req;
  logic [N-1:0] stage_ack;
  logic [N-1:0] rst_n_out;
  logic         seq_busy;
  logic [1:0]   rst_cause;
  logic         ack_timeout;

  rst_seq #(.N_STAGES(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ATO)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
    .stage_ack(stage_ack), .rst_n_out(rst_n_out), .seq_busy(seq_busy),
    .rst_cause(rst_cause), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Timeline model: count of released stages, edge the hold began, edge of the last release.
  int         e       = 0;
  int         m_nrel  = 0;
  bit         m_done  = 1'b0;
  int         m_start = 0;
  int         m_last  = 0;
  logic [1:0] m_cause = 2'b00;
  bit         m_to    = 1'b0;
  logic [N-1:0] exp_rst_n;
  logic         exp_busy;

  task automatic tick();
    bit acked;
    int d;
    @(posedge clk);
    e++;
    if (rst || sw_rst_req || wdt_rst_req) begin
      m_nrel  = 0;
      m_done  = 1'b0;
      m_start = e;
      m_to    = 1'b0;
      m_cause = rst ? 2'b00 : (wdt_rst_req ? 2'b10 : 2'b01);
    end else if (m_nrel == 0) begin
      if (e - m_start == HOLD) begin
        m_nrel = 1;
        m_last = e;
      end
    end else if (!m_done) begin
      d     = e - m_last;
      acked = (d >= GAP) && stage_ack[m_nrel-1];
      if (acked || d == ATO) begin
        if (!acked) m_to = 1'b1;
        if (m_nrel < N) begin
          m_nrel++;
          m_last = e;
        end else begin
          m_done = 1'b1;
        end
      end
    end
    exp_busy  = !m_done;
    exp_rst_n = m_done ? {N{1'b1}} : N'((1 << m_nrel) - 1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int r0 = 0, r1 = 0, r2 = 0, bf = 0;
    rst = 1'b1; sw_rst_req = 1'b0; wdt_rst_req = 1'b0; stage_ack = '1;
    repeat (3) tick();
    checks++;
    if ({rst_n_out, seq_busy, rst_cause, ack_timeout} !== {3'b000, 1'b1, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got rst_n=%b busy=%b cause=%b to=%b want 000 1 00 0",
               rst_n_out, seq_busy, rst_cause, ack_timeout);
    end
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rst_n_out[0] && r0 == 0) r0 = k;
      if (rst_n_out[1] && r1 == 0) r1 = k;
      if (rst_n_out[2] && r2 == 0) r2 = k;
      if (!seq_busy && bf == 0) bf = k;
      checks++;
      if ({rst_n_out, seq_busy, rst_cause, ack_timeout} !== {exp_rst_n, exp_busy, m_cause, m_to}) begin
        failures++;
        $display("FAIL por_model edge %0d got %b%b%b%b want %b%b%b%b", k, rst_n_out, seq_busy,
                 rst_cause, ack_timeout, exp_rst_n, exp_busy, m_cause, m_to);
      end
    end
    checks++;
    if (r0 != 16 || r1 != 20 || r2 != 24 || bf != 28) begin
      failures++;
      $display("FAIL por_timing got rise %0d/%0d/%0d busy_fall %0d want 16/20/24 28", r0, r1, r2, bf);
    end
    checks++;
    if (rst_cause !== 2'b00) begin
      failures++;
      $display("FAIL por_cause got %b want 00", rst_cause);
    end
  endtask

  task automatic test_late_ack();
    int r2 = 0;
    stage_ack = 3'b101;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k == 31) stage_ack = 3'b111;
      tick();
      if (rst_n_out[2] && r2 == 0) r2 = k;
    end
    checks++;
    if (r2 != 31) begin
      failures++;
      $display("FAIL late_ack_rise got %0d want 31", r2);
    end
    checks++;
    if (ack_timeout !== 1'b0) begin
      failures++;
      $display("FAIL late_ack_timeout got %b want 0", ack_timeout);
    end
  endtask

  task automatic test_timeout();
    int r1 = 0, r2 = 0;
    logic to_at_r2 = 1'b0, to_before = 1'b1;
    stage_ack = 3'b101;
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (rst_n_out[1] && r1 == 0) r1 = k;
      if (rst_n_out[2] && r2 == 0) begin r2 = k; to_at_r2 = ack_timeout; end
      if (k == 275) to_before = ack_timeout;
    end
    checks++;
    if (r1 != 20 || r2 != 276) begin
      failures++;
      $display("FAIL timeout_rise got %0d/%0d want 20/276", r1, r2);
    end
    checks++;
    if (to_at_r2 !== 1'b1 || to_before !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flag got at_rise=%b before=%b want 1 0", to_at_r2, to_before);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if ({ack_timeout, rst_cause, rst_n_out} !== {1'b0, 2'b01, 3'b000}) begin
      failures++;
      $display("FAIL timeout_clear got to=%b cause=%b rst_n=%b want 0 01 000",
               ack_timeout, rst_cause, rst_n_out);
    end
  endtask

  task automatic test_dual_req();
    int r0 = 0, bf = 0;
    stage_ack = '1;
    repeat (40) tick();
    checks++;
    if (seq_busy !== 1'b0 || rst_n_out !== 3'b111) begin
      failures++;
      $display("FAIL dual_pre_run got busy=%b rst_n=%b want 0 111", seq_busy, rst_n_out);
    end
    sw_rst_req = 1'b1; wdt_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    checks++;
    if (rst_n_out !== 3'b000 || rst_cause !== 2'b10 || seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL dual_drop got rst_n=%b cause=%b busy=%b want 000 10 1", rst_n_out, rst_cause, seq_busy);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rst_n_out[0] && r0 == 0) r0 = k;
      if (!seq_busy && bf == 0) bf = k;
    end
    checks++;
    if (r0 != 16 || bf != 28) begin
      failures++;
      $display("FAIL dual_replay got rise0 %0d busy_fall %0d want 16 28", r0, bf);
    end
  endtask

  task automatic test_sw_in_rel();
    int r0 = 0;
    stage_ack = '1;
    do_reset();
    repeat (21) tick();
    checks++;
    if (rst_n_out !== 3'b011) begin
      failures++;
      $display("FAIL sw_rel_pre got %b want 011", rst_n_out);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rst_n_out !== 3'b000 || rst_cause !== 2'b01) begin
      failures++;
      $display("FAIL sw_rel_drop got rst_n=%b cause=%b want 000 01", rst_n_out, rst_cause);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rst_n_out[0] && r0 == 0) r0 = k;
    end
    checks++;
    if (r0 != 16) begin
      failures++;
      $display("FAIL sw_rel_rehold got %0d want 16", r0);
    end
  endtask

  task automatic test_rst_in_rel();
    stage_ack = '1;
    do_reset();
    wdt_rst_req = 1'b1;
    tick();
    wdt_rst_req = 1'b0;
    repeat (25) tick();
    checks++;
    if (rst_n_out !== 3'b111 || seq_busy !== 1'b1 || rst_cause !== 2'b10) begin
      failures++;
      $display("FAIL rst_rel_pre got rst_n=%b busy=%b cause=%b want 111 1 10", rst_n_out, seq_busy, rst_cause);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rst_n_out, seq_busy, rst_cause, ack_timeout} !== {3'b000, 1'b1, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL rst_rel_values got %b %b %b %b want 000 1 00 0", rst_n_out, seq_busy, rst_cause, ack_timeout);
    end
  endtask

  task automatic test_random();
    int p = 7;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) p = $urandom_range(0, 8);
      for (int i = 0; i < N; i++) stage_ack[i] = ($urandom_range(0, 7) < p);
      sw_rst_req  = ($urandom_range(0, 299) == 0);
      wdt_rst_req = ($urandom_range(0, 399) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      tick();
      checks++;
      if ({rst_n_out, seq_busy, rst_cause, ack_timeout} !== {exp_rst_n, exp_busy, m_cause, m_to}) begin
        failures++;
        $display("FAIL random_model cycle %0d got %b %b %b %b want %b %b %b %b", k, rst_n_out, seq_busy,
                 rst_cause, ack_timeout, exp_rst_n, exp_busy, m_cause, m_to);
      end
    end
    rst = 1'b0; sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; wdt_rst_req = 1'b0; stage_ack = '1;
    test_reset();
    test_late_ack();
    test_timeout();
    test_dual_req();
    test_sw_in_rel();
    test_rst_in_rel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer for the core's synchronous side. It takes the already-synchronized system reset plus software and watchdog reset requests and holds every downstream domain in reset for a minimum width. It then releases the domains one at a time, in index order, with a per-stage gap and an optional per-stage ready acknowledge. It sits directly downstream of the reset synchronizer and drives the active-low resets of the pipeline, cache/bus and peripheral domains.

## Interface
Parameters:
- N_STAGES, 3: number of reset domains released in sequence (index 0 first); ≥1
- HOLD_CYCLES, 16: minimum cycles all outputs are held asserted; ≥1
- GAP_CYCLES, 4: minimum cycles between release of stage i and stage i+1; ≥1
- ACK_TIMEOUT, 256: cycles to wait for stage_ack[i] before forcing advance; > GAP_CYCLES

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw_rst_req  input  1  software reset request (CSR write), level-sampled each cycle
- wdt_rst_req  input  1  watchdog reset request, level-sampled each cycle
- stage_ack  input  N_STAGES  stage i reports it is out of reset and ready
- rst_n_out  output  N_STAGES  active-low reset per domain
- seq_busy  output  1  1 while any stage is held in reset or the sequence is incomplete
- rst_cause  output  2  cause of the last sequence: 00 rst, 01 sw, 10 wdt
- ack_timeout  output  1  sticky: some stage was advanced past without an ack

## Operation
- States: ASSERT, REL, RUN. Index register idx holds 0..N_STAGES-1. A single counter cnt is sized to hold max(HOLD_CYCLES, ACK_TIMEOUT) and saturates.
- rst=1: state ASSERT, cnt=0, idx=0, rst_n_out=all 0, seq_busy=1, rst_cause=00, ack_timeout=0. This overrides every other input.
- ASSERT:
  - All rst_n_out are 0 and cnt increments.
  - When cnt reaches HOLD_CYCLES-1, go to REL with idx=0, cnt=0, and set rst_n_out[0]=1.
- REL(idx):
  - rst_n_out[j]=1 for every j≤idx; all others stay 0. cnt increments.
  - Advance when cnt ≥ GAP_CYCLES-1 and stage_ack[idx]=1 in the same cycle.
  - Also advance when cnt = ACK_TIMEOUT-1; this sets ack_timeout=1.
  - Advance means: if idx<N_STAGES-1, then idx+1, cnt=0, rst_n_out[idx+1]=1; otherwise go to RUN.
- RUN: all rst_n_out=1, seq_busy=0.
- Request handling: in any state, sw_rst_req=1 or wdt_rst_req=1 sampled on an edge means that on that edge:
  - state goes to ASSERT, cnt=0, idx=0, and all rst_n_out go to 0;
  - ack_timeout clears;
  - rst_cause becomes 10 if wdt_rst_req=1 (wdt wins over a simultaneous sw request), else 01.
- A request that is held high keeps the sequencer in ASSERT, with cnt pinned at 0. The hold window starts on the first edge at which both requests are low.
- stage_ack[i] is ignored while rst_n_out[i]=0. Stages never release out of order. Once a stage is released, it returns to reset only via rst or a request.
- seq_busy = 1 in ASSERT and REL, and 0 only in RUN.

## Timing
- All outputs are registered. Reset values: rst_n_out=0, seq_busy=1, rst_cause=00, ack_timeout=0.
- Edge 1 is the first rising edge with rst=0 and no request. rst_n_out[0] rises at edge HOLD_CYCLES.
- With stage_ack tied high, stage i+1 rises exactly GAP_CYCLES edges after stage i.
- seq_busy falls GAP_CYCLES edges after the last stage rises.
- A late ack (arriving after the gap) advances the sequencer on the edge that samples it: the next stage rises one edge after ack goes high.
- With no ack, the next stage rises ACK_TIMEOUT edges after the current one, and ack_timeout rises on the same edge.
- A request drops all rst_n_out on the sampling edge, i.e. the assertion latency is 1 cycle. This holds mid-sequence too, including on the same edge as a stage advance; the request wins.
- Total release time with acks tied high is HOLD_CYCLES + (N_STAGES-1)·GAP_CYCLES + GAP_CYCLES edges until seq_busy=0.

## Test plan
- POR, defaults, acks tied high; rst high for 3 edges then low → rst_n_out[0] rises at edge 16, [1] at 20, [2] at 24; seq_busy falls at 28; rst_cause=00.
- stage_ack[1] held low until edge 30 → rst_n_out[2] rises at edge 31; ack_timeout stays 0.
- stage_ack[1] never asserted → rst_n_out[2] rises 256 edges after rst_n_out[1], with ack_timeout=1 on that same edge; a later sw_rst_req clears it.
- In RUN, pulse sw_rst_req and wdt_rst_req together for 1 cycle → all rst_n_out=0 on the next edge, rst_cause=10, and the full sequence replays.
- sw_rst_req pulsed while in REL(idx=1) → rst_n_out returns to 000 next edge and the hold restarts, with [0] rising 16 edges later; rst_cause=01.
- rst asserted while in REL(idx=2) → next edge shows all outputs at their reset values.
